// File: rtl/ss_freelist_nway_if.sv
// Free-list interface: dispatch requests and grants, retire returns,
// branch rollback, and status. master = pipeline side, slave = free list.
interface ss_freelist_nway_if #(
  parameter int WIDTH    = 2,
  parameter int FL_SIZE  = 32,
  parameter int PRF_SIZE = 64
);
  localparam int PW = $clog2(PRF_SIZE);
  localparam int FP = $clog2(FL_SIZE) + 1;
  localparam int CW = $clog2(FL_SIZE + 1);

  logic [WIDTH-1:0]    dispatch_en;
  logic [WIDTH-1:0]    retire_en;
  logic [WIDTH*PW-1:0] retire_reg;
  logic                rollback_en;
  logic [FP-1:0]       rollback_head;
  logic [WIDTH*PW-1:0] free_reg;
  logic                grant;
  logic                stall;
  logic [FP-1:0]       head_ptr;
  logic [CW-1:0]       free_cnt;
  logic                fl_err;

  modport master (
    output dispatch_en, retire_en, retire_reg, rollback_en, rollback_head,
    input  free_reg, grant, stall, head_ptr, free_cnt, fl_err
  );

  modport slave (
    input  dispatch_en, retire_en, retire_reg, rollback_en, rollback_head,
    output free_reg, grant, stall, head_ptr, free_cnt, fl_err
  );
endinterface

// File: rtl/ss_freelist_nway.sv
// N-way superscalar physical-register free list. Circular FIFO of free
// PRF tags: dispatch pops up to WIDTH tags per cycle (all-or-nothing),
// retire pushes up to WIDTH tags per cycle. Head can be restored from a
// checkpoint on branch rollback. Pointers carry a wrap bit in the MSB.
module ss_freelist_nway #(
  parameter int WIDTH     = 2,
  parameter int FL_SIZE   = 32,
  parameter int PRF_SIZE  = 64,
  parameter int ZERO_PREG = 0
) (
  input logic               clock,
  input logic               reset,
  ss_freelist_nway_if.slave fl
);
  localparam int PW = $clog2(PRF_SIZE);
  localparam int FP = $clog2(FL_SIZE) + 1;
  localparam int IW = FP - 1;
  localparam int CW = $clog2(FL_SIZE + 1);
  // Wide enough to hold both a pointer difference and a lane count.
  localparam int RW = FP + 4;
  localparam logic [PW-1:0] ZERO_TAG = PW'(ZERO_PREG);
  localparam logic [FP-1:0] FL_FULL  = FP'(FL_SIZE);

  logic [PW-1:0]       entry_r [FL_SIZE];
  logic [FP-1:0]       head_r;
  logic [FP-1:0]       tail_r;
  logic                fl_err_r;

  logic [FP-1:0]       cnt_s;
  logic [FP-1:0]       room_s;
  logic [RW-1:0]       req_s;
  logic                grant_s;
  logic                stall_s;
  logic [WIDTH*PW-1:0] free_reg_s;
  logic [WIDTH-1:0]    wr_en_s;
  logic [IW-1:0]       wr_idx_s [WIDTH];
  logic [FP-1:0]       wr_cnt_s;
  logic                overflow_s;
  logic [FP-1:0]       tail_next_s;
  logic [FP-1:0]       rb_span_s;
  logic                underflow_s;

  assign cnt_s       = tail_r - head_r;
  assign room_s      = FL_FULL - cnt_s;
  assign tail_next_s = tail_r + wr_cnt_s;
  assign rb_span_s   = tail_next_s - fl.rollback_head;
  assign underflow_s = fl.rollback_en && (rb_span_s > FL_FULL);

  // Number of dispatch lanes requesting a tag this cycle.
  always_comb begin
    req_s = '0;
    for (int k = 0; k < WIDTH; k++) begin
      req_s = req_s + RW'(fl.dispatch_en[k]);
    end
  end

  // All-or-nothing grant against the pre-edge occupancy; rollback blocks dispatch.
  always_comb begin
    grant_s = 1'b0;
    stall_s = 1'b0;
    if (fl.rollback_en) begin
      grant_s = 1'b0;
      stall_s = 1'b0;
    end else if (req_s <= RW'(cnt_s)) begin
      grant_s = 1'b1;
    end else begin
      stall_s = 1'b1;
    end
  end

  // Pack consecutive free entries onto the requesting lanes in ascending order.
  always_comb begin : lane_pack
    logic [RW-1:0] slot_v;
    slot_v     = '0;
    free_reg_s = {WIDTH{ZERO_TAG}};
    for (int k = 0; k < WIDTH; k++) begin
      if (grant_s && fl.dispatch_en[k]) begin
        free_reg_s[k*PW +: PW] = entry_r[head_r[IW-1:0] + slot_v[IW-1:0]];
        slot_v = slot_v + RW'(1);
      end else begin
        free_reg_s[k*PW +: PW] = ZERO_TAG;
      end
    end
  end

  // Pack retiring lanes onto consecutive tail slots, dropping any beyond capacity.
  always_comb begin : retire_pack
    logic [RW-1:0] wslot_v;
    wslot_v    = '0;
    wr_en_s    = '0;
    overflow_s = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      wr_idx_s[k] = tail_r[IW-1:0] + wslot_v[IW-1:0];
      if (fl.retire_en[k]) begin
        if (wslot_v < RW'(room_s)) begin
          wr_en_s[k] = 1'b1;
          wslot_v    = wslot_v + RW'(1);
        end else begin
          overflow_s = 1'b1;
        end
      end else begin
        wr_en_s[k] = 1'b0;
      end
    end
    wr_cnt_s = FP'(wslot_v);
  end

  // Head/tail pointers and the sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r   <= '0;
      tail_r   <= FL_FULL;
      fl_err_r <= 1'b0;
    end else begin
      if (fl.rollback_en) begin
        head_r <= fl.rollback_head;
      end else if (grant_s) begin
        head_r <= head_r + FP'(req_s);
      end else begin
        head_r <= head_r;
      end
      tail_r   <= tail_next_s;
      fl_err_r <= fl_err_r | overflow_s | underflow_s;
    end
  end

  // Entry storage: preload the top FL_SIZE tags, then accept retired tags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_r[i] <= PW'(PRF_SIZE - FL_SIZE + i);
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (wr_en_s[k]) begin
          entry_r[wr_idx_s[k]] <= fl.retire_reg[k*PW +: PW];
        end
      end
    end
  end

  assign fl.free_reg = free_reg_s;
  assign fl.grant    = grant_s;
  assign fl.stall    = stall_s;
  assign fl.head_ptr = head_r;
  assign fl.free_cnt = CW'(cnt_s);
  assign fl.fl_err   = fl_err_r;
endmodule

// File: tb/tb_ss_freelist_nway.sv
// Directed bench for ss_freelist_nway (WIDTH=2, FL_SIZE=32, PRF_SIZE=64).
// A reference free-list model pushes expected outputs to a scoreboard queue
// each cycle; observed outputs pop and compare against them. Literal checks
// pin the documented scenario values.
module tb_ss_freelist_nway;
  localparam int WIDTH    = 2;
  localparam int FL_SIZE  = 32;
  localparam int PRF_SIZE = 64;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ss_freelist_nway_if #(.WIDTH(WIDTH), .FL_SIZE(FL_SIZE), .PRF_SIZE(PRF_SIZE)) fl ();

  ss_freelist_nway #(
    .WIDTH(WIDTH), .FL_SIZE(FL_SIZE), .PRF_SIZE(PRF_SIZE), .ZERO_PREG(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fl   (fl)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_entry [FL_SIZE];
  int   m_head;
  int   m_tail;
  bit   m_err;

  logic [31:0] obs_fr0, obs_fr1, obs_grant, obs_stall;

  function automatic int m_cnt();
    return (m_tail - m_head) & 63;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FL_SIZE; i++) m_entry[i] = PRF_SIZE - FL_SIZE + i;
    m_head = 0;
    m_tail = FL_SIZE;
    m_err  = 1'b0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic lit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the negedge, score outputs, advance model over the posedge.
  task automatic cycle(input logic [1:0] disp, input logic [1:0] ret,
                       input logic [5:0] r0, input logic [5:0] r1,
                       input logic rb, input logic [5:0] rbh);
    int req, cnt, j, room;
    int e0, e1;
    bit g, s;
    fl.dispatch_en   = disp;
    fl.retire_en     = ret;
    fl.retire_reg    = {r1, r0};
    fl.rollback_en   = rb;
    fl.rollback_head = rbh;
    #1;
    req = int'(disp[0]) + int'(disp[1]);
    cnt = m_cnt();
    e0 = 0; e1 = 0; g = 1'b0; s = 1'b0;
    if (!rb) begin
      if (req <= cnt) begin
        g = 1'b1;
        j = 0;
        if (disp[0]) begin e0 = m_entry[(m_head + j) % FL_SIZE]; j++; end
        if (disp[1]) begin e1 = m_entry[(m_head + j) % FL_SIZE]; j++; end
      end else begin
        s = 1'b1;
      end
    end
    push("grant", 32'(g));
    push("stall", 32'(s));
    push("free_reg0", 32'(e0));
    push("free_reg1", 32'(e1));
    push("head_ptr", 32'(m_head));
    push("free_cnt", 32'(cnt));
    push("fl_err", 32'(m_err));
    obs_grant = 32'(fl.grant);
    obs_stall = 32'(fl.stall);
    obs_fr0   = 32'(fl.free_reg[5:0]);
    obs_fr1   = 32'(fl.free_reg[11:6]);
    check_next(obs_grant);
    check_next(obs_stall);
    check_next(obs_fr0);
    check_next(obs_fr1);
    check_next(32'(fl.head_ptr));
    check_next(32'(fl.free_cnt));
    check_next(32'(fl.fl_err));
    @(negedge clock);
    room = FL_SIZE - cnt;
    j = 0;
    for (int k = 0; k < 2; k++) begin
      if (ret[k]) begin
        if (j < room) begin
          m_entry[(m_tail + j) % FL_SIZE] = (k == 1) ? int'(r1) : int'(r0);
          j++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    m_tail = (m_tail + j) & 63;
    if (rb) begin
      if (((m_tail - int'(rbh)) & 63) > FL_SIZE) m_err = 1'b1;
      m_head = int'(rbh);
    end else if (g) begin
      m_head = (m_head + req) & 63;
    end
  endtask

  task automatic idle();
    cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    fl.dispatch_en   = 2'b00;
    fl.retire_en     = 2'b00;
    fl.retire_reg    = 12'd0;
    fl.rollback_en   = 1'b0;
    fl.rollback_head = 6'd0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Reset state
    idle();
    lit("rst_grant", obs_grant, 32'd1);
    lit("rst_stall", obs_stall, 32'd0);
    lit("rst_free_reg0", obs_fr0, 32'd0);
    lit("rst_free_cnt", 32'(fl.free_cnt), 32'd32);
    lit("rst_head", 32'(fl.head_ptr), 32'd0);
    lit("rst_fl_err", 32'(fl.fl_err), 32'd0);

    // Two-lane grant from reset
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t1_free_reg0", obs_fr0, 32'd32);
    lit("t1_free_reg1", obs_fr1, 32'd33);
    lit("t1_grant", obs_grant, 32'd1);
    lit("t1_head", 32'(fl.head_ptr), 32'd2);
    lit("t1_free_cnt", 32'(fl.free_cnt), 32'd30);

    // Drain to one entry, then over-request stalls without partial grant
    for (int i = 0; i < 14; i++) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t2_free_cnt", 32'(fl.free_cnt), 32'd1);
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t2_stall", obs_stall, 32'd1);
    lit("t2_grant", obs_grant, 32'd0);
    lit("t2_free_reg0", obs_fr0, 32'd0);
    lit("t2_free_reg1", obs_fr1, 32'd0);
    lit("t2_head_hold", 32'(fl.head_ptr), 32'd31);
    cycle(2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t2_last_tag", obs_fr1, 32'd63);
    lit("t2_empty", 32'(fl.free_cnt), 32'd0);

    // Refill 31 entries, then a single retire on lane 1 lands at entry 31
    for (int i = 0; i < 15; i++) cycle(2'b00, 2'b11, 6'(2 * i), 6'(2 * i + 1), 1'b0, 6'd0);
    cycle(2'b00, 2'b01, 6'd30, 6'd0, 1'b0, 6'd0);
    lit("t4_free_cnt31", 32'(fl.free_cnt), 32'd31);
    cycle(2'b00, 2'b10, 6'd0, 6'd7, 1'b0, 6'd0);
    lit("t4_full", 32'(fl.free_cnt), 32'd32);

    // Grant straddling entry 31 -> 0 with head wrap-bit toggle
    for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t3_head31", 32'(fl.head_ptr), 32'd63);
    cycle(2'b00, 2'b01, 6'd21, 6'd0, 1'b0, 6'd0);
    lit("t3_free_cnt2", 32'(fl.free_cnt), 32'd2);
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t3_free_reg0_e31", obs_fr0, 32'd7);
    lit("t3_free_reg1_e0", obs_fr1, 32'd21);
    lit("t3_head_wrap", 32'(fl.head_ptr), 32'd1);

    // Two-lane retire straddling entry 31 -> 0
    for (int i = 0; i < 15; i++) cycle(2'b00, 2'b11, 6'(32 + i), 6'(48 + i), 1'b0, 6'd0);
    cycle(2'b00, 2'b11, 6'd50, 6'd51, 1'b0, 6'd0);
    lit("t4_full2", 32'(fl.free_cnt), 32'd32);
    for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t4_read_e31", obs_fr0, 32'd50);
    lit("t4_read_e0", obs_fr1, 32'd51);

    // Same-cycle retire is not bypassed; the tag is allocatable next cycle
    cycle(2'b01, 2'b01, 6'd12, 6'd0, 1'b0, 6'd0);
    lit("nobypass_stall", obs_stall, 32'd1);
    cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("retired_next_cycle", obs_fr0, 32'd12);

    // Rollback with concurrent dispatch and retire
    do_reset();
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t5_ckpt", 32'(fl.head_ptr), 32'd5);
    for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t5_cnt_before", 32'(fl.free_cnt), 32'd21);
    cycle(2'b11, 2'b01, 6'd9, 6'd0, 1'b1, 6'd5);
    lit("t5_rb_grant", obs_grant, 32'd0);
    lit("t5_rb_stall", obs_stall, 32'd0);
    lit("t5_rb_free_reg0", obs_fr0, 32'd0);
    lit("t5_head", 32'(fl.head_ptr), 32'd5);
    lit("t5_free_cnt", 32'(fl.free_cnt), 32'd28);
    cycle(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t5_realloc", obs_fr0, 32'd37);

    // Overflow when full: flag sets, tail holds, flag is sticky
    do_reset();
    cycle(2'b00, 2'b01, 6'd3, 6'd0, 1'b0, 6'd0);
    lit("t6_err", 32'(fl.fl_err), 32'd1);
    lit("t6_cnt", 32'(fl.free_cnt), 32'd32);
    for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    lit("t6_sticky", 32'(fl.fl_err), 32'd1);

    // Underflow on rollback, cleared by reset
    do_reset();
    lit("uf_cleared", 32'(fl.fl_err), 32'd0);
    cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 6'd40);
    lit("uf_err", 32'(fl.fl_err), 32'd1);
    lit("uf_head_loaded", 32'(fl.head_ptr), 32'd40);
    do_reset();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
